// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and helpers: hazard metadata carried by every stage
// register, plus the saturating Tnew decrement used on capture and while aging.
package cpu_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int TNEW_W_DEF = 2;
    // Storage width for Tnew; stages narrower than this zero-extend into it.
    localparam int TNEW_MAX_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic [TNEW_MAX_W-1:0] tnew;
    } hazard_meta_t;

    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline stage register: valid bit, hazard metadata and
// payload. Clear only drops the valid bit so the payload stays visible downstream.
module pipe_stage_entry
    import cpu_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 age,
    input  logic                 clear,
    input  hazard_meta_t         load_meta,
    input  logic [PAYLOAD_W-1:0] load_payload,
    output logic                 valid,
    output hazard_meta_t         meta,
    output logic [PAYLOAD_W-1:0] payload
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            meta    <= '0;
            payload <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            meta    <= load_meta;
            payload <= load_payload;
        end else if (age && valid) begin
            meta.tnew <= tnew_dec(meta.tnew);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic handshaked CPU pipeline stage register with hazard metadata export.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready_o.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int TNEW_W    = TNEW_W_DEF,
    parameter bit TNEW_AGE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PAYLOAD_W-1:0]  in_payload_i,
    input  logic [REG_ADDR_W-1:0] in_dst_i,
    input  logic                  in_regwrite_i,
    input  logic [TNEW_W-1:0]     in_tnew_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PAYLOAD_W-1:0]  out_payload_o,
    output logic [REG_ADDR_W-1:0] out_dst_o,
    output logic                  out_regwrite_o,
    output logic [TNEW_W-1:0]     out_tnew_o
);

    // Writes to $0 are stripped here so hazard logic never sees them.
    function automatic hazard_meta_t capture_meta(input logic [REG_ADDR_W-1:0] dst,
                                                  input logic                  regwrite,
                                                  input logic [TNEW_W-1:0]     tnew);
        hazard_meta_t m;
        m.dst      = dst;
        m.regwrite = regwrite & (dst != '0);
        m.tnew     = tnew_dec(TNEW_MAX_W'(tnew));
        return m;
    endfunction

    logic                 in_xfer, out_xfer;
    logic                 main_load, main_age, main_clear, main_v;
    hazard_meta_t         cap_meta, main_d_meta, main_meta;
    logic [PAYLOAD_W-1:0] main_d_payload, main_payload;

    assign cap_meta = capture_meta(in_dst_i, in_regwrite_i, in_tnew_i);
    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = main_v & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_load, skid_age, skid_clear, skid_v, skid_move;
    hazard_meta_t         skid_meta, skid_fwd_meta;
    logic [PAYLOAD_W-1:0] skid_payload;

    // skid_v is a flop, so in_ready_o has no path from out_ready_i.
    assign in_ready_o = ~skid_v;
    assign skid_move  = out_xfer & skid_v;

    // The skid entry is still held while it moves up, so it ages on the way.
    always_comb begin
        skid_fwd_meta = skid_meta;
        if (TNEW_AGE)
            skid_fwd_meta.tnew = tnew_dec(skid_meta.tnew);
    end

    always_comb begin
        main_d_meta    = cap_meta;
        main_d_payload = in_payload_i;
        if (skid_move) begin
            main_d_meta    = skid_fwd_meta;
            main_d_payload = skid_payload;
        end
    end

    assign main_load  = ~flush_i & (skid_move | (in_xfer & (~main_v | out_xfer)));
    assign main_clear = flush_i | (out_xfer & ~skid_move & ~in_xfer);
    assign main_age   = TNEW_AGE & ~out_xfer;
    assign skid_load  = ~flush_i & in_xfer & main_v & ~out_xfer;
    assign skid_clear = flush_i | skid_move;
    assign skid_age   = TNEW_AGE & ~skid_move;

    pipe_stage_entry #(.PAYLOAD_W(PAYLOAD_W)) u_skid (
        .clk          (clk),
        .reset        (reset),
        .load         (skid_load),
        .age          (skid_age),
        .clear        (skid_clear),
        .load_meta    (cap_meta),
        .load_payload (in_payload_i),
        .valid        (skid_v),
        .meta         (skid_meta),
        .payload      (skid_payload)
    );
`else
    assign in_ready_o     = ~main_v | out_ready_i;
    assign main_d_meta    = cap_meta;
    assign main_d_payload = in_payload_i;
    assign main_load      = ~flush_i & in_xfer;
    assign main_clear     = flush_i | (out_xfer & ~in_xfer);
    assign main_age       = TNEW_AGE & ~out_xfer;
`endif

    pipe_stage_entry #(.PAYLOAD_W(PAYLOAD_W)) u_main (
        .clk          (clk),
        .reset        (reset),
        .load         (main_load),
        .age          (main_age),
        .clear        (main_clear),
        .load_meta    (main_d_meta),
        .load_payload (main_d_payload),
        .valid        (main_v),
        .meta         (main_meta),
        .payload      (main_payload)
    );

    assign out_valid_o    = main_v;
    assign out_payload_o  = main_payload;
    assign out_dst_o      = main_meta.dst;
    assign out_regwrite_o = main_v & main_meta.regwrite;
    assign out_tnew_o     = main_v ? main_meta.tnew[TNEW_W-1:0] : '0;

    generate
        if (TNEW_W < TNEW_MAX_W) begin : g_tnew_hi
            logic unused_tnew_hi;
            assign unused_tnew_hi = ^main_meta.tnew[TNEW_MAX_W-1:TNEW_W];
        end
    endgenerate

endmodule
